// File: rtl/axis_buffered_monitor.sv
// -----------------------------------------------------------------------------
// axis_buffered_monitor
//
// AXI4-Stream pass-through that buffers every beat in a first-word-fall-through
// FIFO and monitors the slave-side stream. It sits between a market-data/order
// stream producer and its consumer.
//
// Features
//   - DEPTH-entry FWFT FIFO with real backpressure on s_axis_tready.
//   - Occupancy and a registered almost_full flag.
//   - Counters for accepted beats and for accepted beats carrying tlast.
//   - Sticky proto_err flag. It sets when the upstream source breaks the
//     AXI-Stream rule "once tvalid is high, hold it and hold the payload
//     until the handshake completes".
//
// Ports
//   aclk            clock; all logic is on the rising edge
//   areset          synchronous, active-high reset; overrides everything
//   s_axis_*        slave stream: tdata/tkeep/tuser/tdest/tid/tlast/tvalid in,
//                   tready out (high whenever the FIFO is not full and not
//                   in reset)
//   m_axis_*        master stream: payload/tvalid out, tready in; the payload
//                   reads as all-zero whenever tvalid is low
//   occupancy       number of entries currently stored (0..DEPTH)
//   almost_full     registered, high when occupancy >= AF_THRESH
//   beat_count      accepted slave beats, wraps modulo 2^CNT_WIDTH
//   pkt_count       accepted slave beats with tlast=1, wraps modulo 2^CNT_WIDTH
//   proto_err       sticky handshake-violation flag
//   err_clear       clears proto_err; a new violation at the same edge wins
// -----------------------------------------------------------------------------
module axis_buffered_monitor #(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 4,
    parameter int DEST_WIDTH = 4,
    parameter int ID_WIDTH   = 4,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = 12,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                      aclk,
    input  logic                      areset,

    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic [USER_WIDTH-1:0]     s_axis_tuser,
    input  logic [DEST_WIDTH-1:0]     s_axis_tdest,
    input  logic [ID_WIDTH-1:0]       s_axis_tid,
    input  logic                      s_axis_tlast,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,

    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic [USER_WIDTH-1:0]     m_axis_tuser,
    output logic [DEST_WIDTH-1:0]     m_axis_tdest,
    output logic [ID_WIDTH-1:0]       m_axis_tid,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,

    output logic [$clog2(DEPTH):0]    occupancy,
    output logic                      almost_full,
    output logic [CNT_WIDTH-1:0]      beat_count,
    output logic [CNT_WIDTH-1:0]      pkt_count,
    output logic                      proto_err,
    input  logic                      err_clear
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int AW         = $clog2(DEPTH);
    // Every sideband field travels with the data through one memory word.
    localparam int PW         = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH
                              + DEST_WIDTH + ID_WIDTH + 1;

    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] AF_LEVEL   = (AW + 1)'(AF_THRESH);

    // -------------------------------------------------------------------------
    // Storage and pointers
    // -------------------------------------------------------------------------
    logic [PW-1:0] mem [DEPTH];

    // Write and read counters carry one bit more than the address. Their
    // difference is the occupancy, and the extra bit tells full from empty.
    logic [AW:0]   wr_cnt;
    logic [AW:0]   rd_cnt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic [PW-1:0] s_payload;
    logic [PW-1:0] m_payload;

    logic          full;
    logic          push;
    logic          pop;
    logic [AW:0]   occ_next;

    assign wr_ptr    = wr_cnt[AW-1:0];
    assign rd_ptr    = rd_cnt[AW-1:0];
    assign occupancy = wr_cnt - rd_cnt;
    assign full      = (occupancy == FULL_LEVEL);

    assign s_payload = {s_axis_tlast, s_axis_tid, s_axis_tdest,
                        s_axis_tuser, s_axis_tkeep, s_axis_tdata};

    // tready depends only on stored state and on reset. It never looks at
    // m_axis_tready, so a pop while full frees the slot for the next cycle
    // only.
    assign s_axis_tready = ~areset & ~full;
    assign push          = s_axis_tvalid & s_axis_tready;

    // FWFT: the head entry is presented as soon as it is stored. The payload
    // is forced to zero while empty so stale memory never leaks out after a
    // flush.
    assign m_axis_tvalid = (occupancy != '0);
    assign pop           = m_axis_tvalid & m_axis_tready;
    assign m_payload     = m_axis_tvalid ? mem[rd_ptr] : '0;

    assign {m_axis_tlast, m_axis_tid, m_axis_tdest,
            m_axis_tuser, m_axis_tkeep, m_axis_tdata} = m_payload;

    // NOTE: the storage array is deliberately left out of reset. The pointers
    // define which words are valid, and a memory without reset maps onto RAM
    // primitives instead of a wall of flops.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr] <= s_payload;
        end
    end

    // NOTE: every sequential block uses non-blocking assignments only, so
    // each register samples the values from before the edge, whatever order
    // the blocks are evaluated in.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (push) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
            if (pop) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // almost_full: compute the occupancy after this edge so that the flag
    // changes in the same cycle as occupancy.
    // -------------------------------------------------------------------------
    // NOTE: the default assignment at the top of the block keeps every path
    // assigned, so no latch is inferred.
    always_comb begin
        occ_next = occupancy;
        unique case ({push, pop})
            2'b10:   occ_next = occupancy + 1'b1;
            2'b01:   occ_next = occupancy - 1'b1;
            default: occ_next = occupancy;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (occ_next >= AF_LEVEL);
        end
    end

    // -------------------------------------------------------------------------
    // Beat and packet counters, both free-running and wrapping
    // -------------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            beat_count <= '0;
            pkt_count  <= '0;
        end else if (push) begin
            beat_count <= beat_count + 1'b1;
            if (s_axis_tlast) begin
                pkt_count <= pkt_count + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Handshake monitor
    //
    // A stalled beat is one offered (tvalid=1) while tready=0. At the next
    // edge the source must still offer it, with an identical payload.
    // Dropping tvalid or changing any field is a violation. The check does
    // not gate the datapath: whatever is offered is still pushed as normal.
    // -------------------------------------------------------------------------
    logic          stall_q;
    logic [PW-1:0] snap_q;
    logic          violation;

    assign violation = stall_q & (~s_axis_tvalid | (s_payload != snap_q));

    always_ff @(posedge aclk) begin
        if (areset) begin
            stall_q   <= 1'b0;
            snap_q    <= '0;
            proto_err <= 1'b0;
        end else begin
            stall_q   <= s_axis_tvalid & ~s_axis_tready;
            snap_q    <= s_payload;
            // A new violation beats a clear at the same edge.
            proto_err <= violation | (proto_err & ~err_clear);
        end
    end

endmodule

// File: tb/tb_axis_buffered_monitor.sv
module tb_axis_buffered_monitor;

    localparam int DEPTH = 16;
    localparam int AF    = 12;

    typedef struct packed {
        logic        last;
        logic [3:0]  id;
        logic [3:0]  dest;
        logic [3:0]  user;
        logic [3:0]  keep;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        logic        rst;
        logic        valid;
        logic [31:0] data;
        logic        last;
        logic        mready;
        logic [4:0]  e_occ;
        logic        e_mvalid;
        logic [31:0] e_mdata;
        logic        e_mlast;
        logic        e_sready;
        logic [31:0] e_beat;
        logic [31:0] e_pkt;
    } vec_t;

    // ------------------------------------------------------------------ DUTs
    logic  aclk = 1'b0;
    logic  areset = 1'b1;
    beat_t s_beat = '0;
    logic  s_valid = 1'b0;
    logic  m_ready = 1'b0;
    logic  err_clear = 1'b0;

    wire [31:0] s_tdata = s_beat.data;
    wire [3:0]  s_tkeep = s_beat.keep;
    wire [3:0]  s_tuser = s_beat.user;
    wire [3:0]  s_tdest = s_beat.dest;
    wire [3:0]  s_tid   = s_beat.id;
    wire        s_tlast = s_beat.last;

    logic        s_tready, m_tvalid, m_tlast, af, perr;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep, m_tuser, m_tdest, m_tid;
    logic [4:0]  occ;
    logic [31:0] beat_cnt, pkt_cnt;

    logic        w_sready, w_mvalid, w_mlast, w_af, w_perr;
    logic [31:0] w_tdata;
    logic [3:0]  w_tkeep, w_tuser, w_tdest, w_tid;
    logic [4:0]  w_occ;
    logic [3:0]  w_beat, w_pkt;

    always #5 aclk = ~aclk;

    axis_buffered_monitor u_dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
        .s_axis_tdest(s_tdest), .s_axis_tid(s_tid), .s_axis_tlast(s_tlast),
        .s_axis_tvalid(s_valid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
        .m_axis_tdest(m_tdest), .m_axis_tid(m_tid), .m_axis_tlast(m_tlast),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_ready),
        .occupancy(occ), .almost_full(af), .beat_count(beat_cnt),
        .pkt_count(pkt_cnt), .proto_err(perr), .err_clear(err_clear)
    );

    // Narrow-counter build, driven by the same stimulus, for the wrap check.
    axis_buffered_monitor #(.CNT_WIDTH(4)) u_dut_w4 (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
        .s_axis_tdest(s_tdest), .s_axis_tid(s_tid), .s_axis_tlast(s_tlast),
        .s_axis_tvalid(s_valid), .s_axis_tready(w_sready),
        .m_axis_tdata(w_tdata), .m_axis_tkeep(w_tkeep), .m_axis_tuser(w_tuser),
        .m_axis_tdest(w_tdest), .m_axis_tid(w_tid), .m_axis_tlast(w_mlast),
        .m_axis_tvalid(w_mvalid), .m_axis_tready(m_ready),
        .occupancy(w_occ), .almost_full(w_af), .beat_count(w_beat),
        .pkt_count(w_pkt), .proto_err(w_perr), .err_clear(err_clear)
    );

    // ---------------------------------------------------------------- model
    beat_t       q[$];
    int unsigned m_beat = 0;
    int unsigned m_pkt  = 0;
    logic        m_perr = 1'b0;
    logic        m_stall = 1'b0;
    beat_t       m_snap = '0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic beat_t dut_out();
        return {m_tlast, m_tid, m_tdest, m_tuser, m_tkeep, m_tdata};
    endfunction

    function automatic beat_t w4_out();
        return {w_mlast, w_tid, w_tdest, w_tuser, w_tkeep, w_tdata};
    endfunction

    // One clock: advance the queue model by the stream rules, then compare.
    task automatic cycle();
        bit    ready, push, pop, viol;
        beat_t head;
        ready = !areset && (q.size() != DEPTH);
        @(posedge aclk);
        if (areset) begin
            q.delete();
            m_beat  = 0;
            m_pkt   = 0;
            m_perr  = 1'b0;
            m_stall = 1'b0;
        end else begin
            push    = s_valid && ready;
            pop     = (q.size() != 0) && m_ready;
            viol    = m_stall && (!s_valid || (s_beat != m_snap));
            m_perr  = viol || (m_perr && !err_clear);
            m_stall = s_valid && !ready;
            m_snap  = s_beat;
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(s_beat);
                m_beat++;
                if (s_beat.last) m_pkt++;
            end
        end
        #1;
        head = (q.size() != 0) ? q[0] : beat_t'('0);
        check("occupancy",   occ,      q.size());
        check("almost_full", af,       q.size() >= AF);
        check("m_tvalid",    m_tvalid, q.size() != 0);
        check("m_payload",   dut_out(), head);
        check("s_tready",    s_tready, !areset && (q.size() != DEPTH));
        check("beat_count",  beat_cnt, m_beat);
        check("pkt_count",   pkt_cnt,  m_pkt);
        check("proto_err",   perr,     m_perr);
        check("w4_beat",     w_beat,   m_beat % 16);
        check("w4_pkt",      w_pkt,    m_pkt % 16);
        check("w4_occ",      w_occ,    q.size());
        check("w4_payload",  w4_out(), head);
        check("w4_flags",    {w_sready, w_mvalid, w_af, w_perr},
                             {s_tready === 1'b1 ? 1'b1 : 1'b0, q.size() != 0, q.size() >= AF, m_perr});
    endtask

    task automatic do_reset();
        areset    = 1'b1;
        s_valid   = 1'b0;
        err_clear = 1'b0;
        s_beat    = '0;
        cycle();
        areset = 1'b0;
    endtask

    task automatic fill_full(input logic [31:0] base);
        m_ready = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            s_beat      = '0;
            s_beat.data = base + i;
            cycle();
        end
    endtask

    task automatic drain();
        s_valid   = 1'b0;
        err_clear = 1'b0;
        m_ready   = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) cycle();
    endtask

    // ------------------------------------------------------------- watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- tests
    vec_t vecs[11];

    initial begin
        //            rst val data   lst mrdy | occ mv mdata  ml sr beat pkt
        vecs[0]  = '{1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 5'd0, 1'b0, 32'h00, 1'b0, 1'b0, 32'd0, 32'd0};
        vecs[1]  = '{1'b0, 1'b1, 32'h11, 1'b0, 1'b1, 5'd1, 1'b1, 32'h11, 1'b0, 1'b1, 32'd1, 32'd0};
        vecs[2]  = '{1'b0, 1'b1, 32'h22, 1'b0, 1'b1, 5'd1, 1'b1, 32'h22, 1'b0, 1'b1, 32'd2, 32'd0};
        vecs[3]  = '{1'b0, 1'b1, 32'h33, 1'b1, 1'b1, 5'd1, 1'b1, 32'h33, 1'b1, 1'b1, 32'd3, 32'd1};
        vecs[4]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 5'd0, 1'b0, 32'h00, 1'b0, 1'b1, 32'd3, 32'd1};
        vecs[5]  = '{1'b0, 1'b1, 32'hAA, 1'b0, 1'b0, 5'd1, 1'b1, 32'hAA, 1'b0, 1'b1, 32'd4, 32'd1};
        vecs[6]  = '{1'b0, 1'b1, 32'hBB, 1'b0, 1'b0, 5'd2, 1'b1, 32'hAA, 1'b0, 1'b1, 32'd5, 32'd1};
        vecs[7]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 5'd2, 1'b1, 32'hAA, 1'b0, 1'b1, 32'd5, 32'd1};
        vecs[8]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 5'd1, 1'b1, 32'hBB, 1'b0, 1'b1, 32'd5, 32'd1};
        vecs[9]  = '{1'b1, 1'b1, 32'hCC, 1'b1, 1'b1, 5'd0, 1'b0, 32'h00, 1'b0, 1'b0, 32'd0, 32'd0};
        vecs[10] = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 5'd0, 1'b0, 32'h00, 1'b0, 1'b1, 32'd0, 32'd0};

        // T1 plus hold/reset corners, table-driven
        for (int i = 0; i < 11; i++) begin
            s_beat      = '0;
            s_beat.data = vecs[i].data;
            s_beat.last = vecs[i].last;
            areset      = vecs[i].rst;
            s_valid     = vecs[i].valid;
            m_ready     = vecs[i].mready;
            err_clear   = 1'b0;
            cycle();
            check($sformatf("vec%0d_occ", i),    occ,      vecs[i].e_occ);
            check($sformatf("vec%0d_mvalid", i), m_tvalid, vecs[i].e_mvalid);
            check($sformatf("vec%0d_mdata", i),  m_tdata,  vecs[i].e_mdata);
            check($sformatf("vec%0d_mlast", i),  m_tlast,  vecs[i].e_mlast);
            check($sformatf("vec%0d_sready", i), s_tready, vecs[i].e_sready);
            check($sformatf("vec%0d_beat", i),   beat_cnt, vecs[i].e_beat);
            check($sformatf("vec%0d_pkt", i),    pkt_cnt,  vecs[i].e_pkt);
        end

        // T2: fill to full, almost_full threshold, pop while full
        do_reset();
        m_ready = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            s_beat      = '0;
            s_beat.data = 32'h100 + i;
            cycle();
            check($sformatf("t2_af_%0d", i + 1), af, (i + 1) >= AF);
        end
        check("t2_full_occ", occ, 5'd16);
        check("t2_full_sready", s_tready, 1'b0);
        s_beat.data = 32'h200;
        cycle();
        check("t2_stall_occ", occ, 5'd16);
        m_ready = 1'b1;
        cycle();
        check("t2_pop_full_no_push", occ, 5'd15);
        check("t2_sready_next", s_tready, 1'b1);
        m_ready = 1'b0;
        cycle();
        check("t2_refill_occ", occ, 5'd16);
        check("t2_no_err", perr, 1'b0);
        drain();

        // T3: payload change while stalled, clear, set-wins, tvalid drop
        do_reset();
        fill_full(32'h300);
        s_beat.data = 32'hA5;
        cycle();
        check("t3_stall_ok", perr, 1'b0);
        s_beat.data = 32'h5A;
        cycle();
        check("t3_set", perr, 1'b1);
        err_clear = 1'b1;
        cycle();
        check("t3_clear", perr, 1'b0);
        s_beat.data = 32'hA5;
        cycle();
        check("t3_set_wins", perr, 1'b1);
        cycle();
        check("t3_clear2", perr, 1'b0);
        err_clear = 1'b0;
        s_valid   = 1'b0;
        cycle();
        check("t3_valid_drop", perr, 1'b1);
        err_clear = 1'b1;
        cycle();
        check("t3_clear3", perr, 1'b0);
        drain();

        // T4: preload 5, then 40 beats of simultaneous push and pop
        do_reset();
        m_ready = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_beat      = '0;
            s_beat.data = 32'h400 + i;
            cycle();
        end
        m_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            s_beat      = '0;
            s_beat.data = 32'h500 + i;
            s_beat.last = (i % 8 == 7);
            cycle();
            check($sformatf("t4_occ_%0d", i), occ, 5'd5);
        end
        check("t4_beats", beat_cnt, 32'd45);
        drain();

        // T5: reset mid-packet with 7 stored and the output stalled
        do_reset();
        m_ready = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            s_beat      = '0;
            s_beat.data = 32'h600 + i;
            cycle();
        end
        check("t5_occ7", occ, 5'd7);
        areset = 1'b1;
        cycle();
        check("t5_occ", occ, 5'd0);
        check("t5_mvalid", m_tvalid, 1'b0);
        check("t5_mdata", m_tdata, 32'd0);
        check("t5_counts", {beat_cnt, pkt_cnt}, 64'd0);
        areset  = 1'b0;
        s_valid = 1'b0;
        #1;
        check("t5_sready", s_tready, 1'b1);

        // T6: 4-bit counters wrap after 16 beats
        m_ready = 1'b1;
        s_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            s_beat      = '0;
            s_beat.data = 32'h700 + i;
            s_beat.last = 1'b1;
            cycle();
        end
        check("t6_beat15", w_beat, 4'd15);
        s_beat.data = 32'h7FF;
        cycle();
        check("t6_beat_wrap", w_beat, 4'd0);
        check("t6_pkt_wrap", w_pkt, 4'd0);
        check("t6_beat_wide", beat_cnt, 32'd16);
        drain();

        // Random traffic against the queue model
        do_reset();
        for (int i = 0; i < 700; i++) begin
            areset    = ($urandom_range(149, 0) == 0);
            err_clear = ($urandom_range(19, 0) == 0);
            m_ready   = ($urandom_range(99, 0) < ((i < 350) ? 30 : 80));
            if (m_stall && s_valid) begin
                s_valid = ($urandom_range(99, 0) < 97);
                if ($urandom_range(49, 0) == 0) s_beat.data = $urandom;
            end else begin
                s_valid = ($urandom_range(99, 0) < 70);
                s_beat  = beat_t'({$urandom, $urandom});
            end
            cycle();
        end
        areset = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
